// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory among NUM_REQ requesters, one transaction at a time.
// Round-robin by default; define MEM_ARBITER_FIXED_PRIORITY_EN to make the lowest index always win.
module mem_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          done,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        busy,
   output logic [ADDR_W-1:0]           mem_address,
   output logic                        mem_read_write,
   output logic [DATA_W-1:0]           mem_data_in,
   output logic                        mem_enabled,
   input  logic [DATA_W-1:0]           mem_data_out
);
   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

   state_t              r_state;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  r_done;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_busy;
   logic [ADDR_W-1:0]   r_mem_address;
   logic                r_mem_read_write;
   logic [DATA_W-1:0]   r_mem_data_in;
   logic                r_mem_enabled;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
   logic [PTR_W-1:0]    r_rr_ptr;
`endif

   logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
   logic [DATA_W-1:0]   w_wdata [NUM_REQ];
   logic [PTR_W-1:0]    w_winner;
   logic                w_any;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan from the highest search offset down so the first set bit in search order wins.
   always_comb begin
      int w_idx;
      w_any    = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
         w_idx = k;
`else
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
`endif
         if (req[w_idx[PTR_W-1:0]]) begin
            w_any    = 1'b1;
            w_winner = w_idx[PTR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_grant          <= '0;
         r_done           <= '0;
         r_rd_data        <= '0;
         r_busy           <= 1'b0;
         r_mem_address    <= '0;
         r_mem_read_write <= 1'b0;
         r_mem_data_in    <= '0;
         r_mem_enabled    <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
         r_rr_ptr         <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant          <= NUM_REQ'(1) << w_winner;
                  r_mem_address    <= w_addr[w_winner];
                  r_mem_data_in    <= w_wdata[w_winner];
                  r_mem_read_write <= req_rw[w_winner];
                  r_mem_enabled    <= 1'b1;
                  r_busy           <= 1'b1;
                  r_state          <= S_ISSUE;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
                  r_rr_ptr <= (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
`endif
               end
            end
            S_ISSUE: begin
               r_mem_enabled <= 1'b0;
               r_state       <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // Read data is valid one cycle after the enable edge; writes keep the old value.
               if (r_mem_read_write) r_rd_data <= mem_data_out;
               r_done  <= r_grant;
               r_state <= S_DONE;
            end
            default: begin
               r_done  <= '0;
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant          = r_grant;
   assign done           = r_done;
   assign rd_data        = r_rd_data;
   assign busy           = r_busy;
   assign mem_address    = r_mem_address;
   assign mem_read_write = r_mem_read_write;
   assign mem_data_in    = r_mem_data_in;
   assign mem_enabled    = r_mem_enabled;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port 256 x 32-bit shared memory among `NUM_REQ` requesters. Each requester posts one read or write transaction with a level request. The arbiter selects a winner, drives the memory's address, read/write, data-in and enable lines for exactly one cycle, captures read data, and returns a one-cycle `done` pulse. It sits between the requester modules and the memory; nothing else drives the memory ports.

## Interface
Parameters:
- `NUM_REQ`, default 4, number of requesters (legal range 2..8).
- `ADDR_W`, default 8, memory address width.
- `DATA_W`, default 32, memory word width.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `req`  in  NUM_REQ  per-requester transaction request (level).
- `req_rw`  in  NUM_REQ  per-requester op: 1 = read, 0 = write.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data, sliced the same way.
- `grant`  out  NUM_REQ  one-hot owner of the current transaction.
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `rd_data`  out  DATA_W  read result; valid while `done` is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_read_write`  out  1  to memory `readWrite`.
- `mem_data_in`  out  DATA_W  to memory `dataIn`.
- `mem_enabled`  out  1  to memory `enabled`.
- `mem_data_out`  in  DATA_W  from memory `dataOut` (registered in the memory, 1-cycle read).

## Operation
- All outputs are registered. Reset value of every output is 0. The round-robin pointer `rr_ptr` resets to 0 and the state resets to IDLE.
- The FSM has four states: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE.
- **IDLE:** if any `req` bit is set, choose the winner w as the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ, wrapping past NUM_REQ-1 to 0. On the same edge:
  - `grant[w]`<=1
  - `mem_address`/`mem_data_in`/`mem_read_write` <= slices of w
  - `mem_enabled`<=1
  - `rr_ptr`<=(w+1) mod NUM_REQ
  - state <= ISSUE.
  If no `req` bit is set, nothing changes.
- **ISSUE:** `mem_enabled` is high for this cycle only. On the exit edge the memory commits the write or latches the read, `mem_enabled`<=0, and state <= CAPTURE.
- **CAPTURE:** `rd_data`<=`mem_data_out` for reads only; `rd_data` holds its value on writes. `done[w]`<=1. State <= DONE.
- **DONE:** `done[w]` is high for this one cycle. On the exit edge `done`<=0, `grant`<=0, state <= IDLE. `req` is ignored in DONE.
- Requester rules:
  - Hold `req`, `req_rw`, `req_addr` and `req_wdata` stable from assertion until `done` is seen.
  - Deassert `req` on the edge ending the `done` cycle.
  - A `req` still high in the following IDLE cycle is a new transaction.
- Request inputs are sampled only in IDLE. Changes in other states have no effect.
- `rr_ptr` is updated only on grant.

## Timing
- Let edge E0 be the IDLE edge that sees `req[i]`. Then:
  - E0 -> ISSUE (`grant`, `mem_*` valid, `mem_enabled`=1).
  - E1 -> memory op and CAPTURE.
  - E2 -> `done`/`rd_data` valid.
  - E3 -> IDLE.
- Request-to-`done` latency is 3 edges; back-to-back throughput is one transaction per 4 cycles.
- Simultaneous requests: exactly one winner per IDLE cycle. Losers keep `req` high and are served in pointer order. No requester waits more than NUM_REQ-1 transactions.
- Reset mid-operation returns to IDLE and clears all outputs on the reset edge, with no `done` for the aborted transaction. If reset is asserted during ISSUE, the memory still sees `enabled`=1 at that edge and the operation commits; this is accepted behaviour.
- Pointer wrap: a grant to NUM_REQ-1 sets `rr_ptr` to 0.

## Configuration
- Macro: `MEM_ARBITER_FIXED_PRIORITY_EN`.
  - Defined: the winner is always the lowest-index set `req` bit, and `rr_ptr` is absent or unused. Starvation of higher indices is permitted.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single write then read.** req[1] writes addr 0x10 data 0xDEADBEEF. Expect `done[1]` 3 cycles after request and memory[0x10]=0xDEADBEEF. Then req[1] reads 0x10: expect `rd_data`=0xDEADBEEF while `done[1]` is high.
- **All four request together.** Each reads a distinct preloaded address. Expect grant order 0,1,2,3, each `done` exactly 4 cycles apart, and each `rd_data` correct.
- **Pointer wrap.** After a grant to 3, req[0] and req[2] assert. Expect 0 then 2. Repeat with grant to 2 pending: expect 3 before 0.
- **Held request.** req[2] held high across `done` for two transactions. Expect two separate 4-cycle transactions and `mem_enabled` high exactly one cycle each.
- **Reset mid-operation.** Assert `reset` in CAPTURE. Expect all outputs 0 next cycle, no `done`, `busy`=0, and a subsequent request served normally starting at requester 0.
- **Fixed priority.** With `MEM_ARBITER_FIXED_PRIORITY_EN` defined, req[0] and req[3] held continuously. Expect requester 0 granted on every transaction and requester 3 never granted.
